// File: rtl/decode_stage_p.sv
// Decode stage: ID slot, register file with optional write-back bypass, load-use
// hazard stall, and a registered, back-pressurable output towards EX.
module decode_stage_p #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_in,
    input  logic [31:0]     instr_in,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            wb_we,
    input  logic [RW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_read_mem,
    input  logic [RW-1:0]   ex_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     ctrl_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] rs1_data_out,
    output logic [XLEN-1:0] rs2_data_out,
    output logic [XLEN-1:0] imm_out,
    output logic [RW-1:0]   rs1_out,
    output logic [RW-1:0]   rs2_out,
    output logic [RW-1:0]   rd_out,
    output logic [2:0]      funct3_out,
    output logic [15:0]     stall_cnt
);
    // Handshakes: a transfer happens on a rising edge where valid && ready; a
    // producer holds valid and payload stable until that edge.
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
    // Control bundle bit positions, MSB first.
    localparam int C_WR = 15, C_WRS = 14, C_RM = 13, C_WM = 12, C_BR = 11, C_UB = 10,
                   C_AS = 9, C_BS = 8, C_SC = 7, C_RS = 5, C_ALU = 2, C_LEFT = 1, C_ARITM = 0;

    logic [XLEN-1:0] regs_q [NREGS];
    logic            id_valid_q;
    logic [31:0]     id_instr_q;
    logic [XLEN-1:0] id_pc_q;
    logic            out_valid_q;
    logic [15:0]     ctrl_q, stall_q;
    logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
    logic [RW-1:0]   rs1_q, rs2_q, rd_q;
    logic [2:0]      funct3_q;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1_f, rs2_f, rd_f;
    logic [RW-1:0]   rs1_idx, rs2_idx, rd_idx;
    logic [15:0]     ctrl_d;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_d, rs1_data_d, rs2_data_d;
    logic            rs2_used, hazard, advance, accept;

    assign opcode  = id_instr_q[6:0];
    assign funct3  = id_instr_q[14:12];
    assign rd_f    = id_instr_q[11:7];
    assign rs1_f   = id_instr_q[19:15];
    assign rs2_f   = id_instr_q[24:20];
    assign rd_idx  = rd_f[RW-1:0];
    assign rs1_idx = rs1_f[RW-1:0];
    assign rs2_idx = rs2_f[RW-1:0];

    always_comb begin
        ctrl_d   = '0;
        imm32    = '0;
        rs2_used = 1'b0;
        case (opcode)
            OP_LUI: begin
                ctrl_d[C_WR] = 1'b1; ctrl_d[C_BS] = 1'b1; ctrl_d[C_RS +: 2] = 2'b10;
                imm32 = {id_instr_q[31:12], 12'b0};
            end
            OP_AUIPC: begin
                ctrl_d[C_WR] = 1'b1; ctrl_d[C_AS] = 1'b1; ctrl_d[C_BS] = 1'b1;
                imm32 = {id_instr_q[31:12], 12'b0};
            end
            OP_JAL: begin
                ctrl_d[C_WR] = 1'b1; ctrl_d[C_UB] = 1'b1; ctrl_d[C_AS] = 1'b1;
                ctrl_d[C_BS] = 1'b1; ctrl_d[C_RS +: 2] = 2'b01;
                imm32 = {{11{id_instr_q[31]}}, id_instr_q[31], id_instr_q[19:12],
                         id_instr_q[20], id_instr_q[30:21], 1'b0};
            end
            OP_JALR: begin
                ctrl_d[C_WR] = 1'b1; ctrl_d[C_UB] = 1'b1; ctrl_d[C_BS] = 1'b1;
                ctrl_d[C_RS +: 2] = 2'b01;
                imm32 = {{20{id_instr_q[31]}}, id_instr_q[31:20]};
            end
            OP_BRANCH: begin
                ctrl_d[C_BR] = 1'b1; ctrl_d[C_SC] = !funct3[1];
                rs2_used = 1'b1;
                imm32 = {{19{id_instr_q[31]}}, id_instr_q[31], id_instr_q[7],
                         id_instr_q[30:25], id_instr_q[11:8], 1'b0};
            end
            OP_LOAD: begin
                ctrl_d[C_WR] = 1'b1; ctrl_d[C_WRS] = 1'b1; ctrl_d[C_RM] = 1'b1;
                ctrl_d[C_BS] = 1'b1;
                imm32 = {{20{id_instr_q[31]}}, id_instr_q[31:20]};
            end
            OP_STORE: begin
                ctrl_d[C_WM] = 1'b1; ctrl_d[C_BS] = 1'b1;
                rs2_used = 1'b1;
                imm32 = {{20{id_instr_q[31]}}, id_instr_q[31:25], id_instr_q[11:7]};
            end
            OP_IMM: begin
                ctrl_d[C_WR] = 1'b1; ctrl_d[C_BS] = 1'b1; ctrl_d[C_ALU +: 3] = funct3;
                ctrl_d[C_SC] = (funct3 == 3'b010);
                ctrl_d[C_LEFT] = (funct3 == 3'b001);
                ctrl_d[C_ARITM] = (funct3 == 3'b101) && id_instr_q[30];
                imm32 = {{20{id_instr_q[31]}}, id_instr_q[31:20]};
            end
            OP_REG: begin
                ctrl_d[C_WR] = 1'b1; ctrl_d[C_ALU +: 3] = funct3;
                ctrl_d[C_SC] = (funct3 == 3'b010);
                ctrl_d[C_LEFT] = (funct3 == 3'b001);
                ctrl_d[C_ARITM] = id_instr_q[30] && (funct3 == 3'b000 || funct3 == 3'b101);
                rs2_used = 1'b1;
            end
            default: begin
                ctrl_d = '0;
            end
        endcase
    end

    assign imm_d = XLEN'($signed(imm32));

    // A write-back landing this cycle is forwarded so the operand is never stale.
    always_comb begin
        rs1_data_d = regs_q[rs1_idx];
        if (BYPASS != 0 && wb_we && wb_rd == rs1_idx && rs1_idx != '0) rs1_data_d = wb_data;
    end

    always_comb begin
        rs2_data_d = regs_q[rs2_idx];
        if (BYPASS != 0 && wb_we && wb_rd == rs2_idx && rs2_idx != '0) rs2_data_d = wb_data;
    end

    assign hazard   = id_valid_q && ex_read_mem && ex_rd != '0 &&
                      (ex_rd == rs1_idx || (rs2_used && ex_rd == rs2_idx));
    assign advance  = id_valid_q && !hazard && (!out_valid_q || out_ready);
    assign in_ready = rst_n && (!id_valid_q || advance);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wb_we && wb_rd != '0) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_valid_q  <= 1'b0;
            id_instr_q  <= '0;
            id_pc_q     <= '0;
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            funct3_q    <= '0;
            stall_q     <= '0;
        end else begin
            if (flush) begin
                id_valid_q <= 1'b0;
            end else if (accept) begin
                id_valid_q <= 1'b1;
                id_instr_q <= instr_in;
                id_pc_q    <= pc_in;
            end else if (advance) begin
                id_valid_q <= 1'b0;
            end

            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (advance) begin
                out_valid_q <= 1'b1;
                ctrl_q      <= ctrl_d;
                pc_q        <= id_pc_q;
                rs1_data_q  <= rs1_data_d;
                rs2_data_q  <= rs2_data_d;
                imm_q       <= imm_d;
                rs1_q       <= rs1_idx;
                rs2_q       <= rs2_idx;
                rd_q        <= rd_idx;
                funct3_q    <= funct3;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (hazard && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
        end
    end

    assign out_valid    = out_valid_q;
    assign ctrl_out     = ctrl_q;
    assign pc_out       = pc_q;
    assign rs1_data_out = rs1_data_q;
    assign rs2_data_out = rs2_data_q;
    assign imm_out      = imm_q;
    assign rs1_out      = rs1_q;
    assign rs2_out      = rs2_q;
    assign rd_out       = rd_q;
    assign funct3_out   = funct3_q;
    assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: directed vectors into a scoreboard queue, a negedge
// monitor that pops on each output transfer, plus direct timing/flush/reset checks.
module tb_decode_stage_p;
    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] ctrl;
        logic [31:0] imm;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] rs2nb;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_in, instr_in, wb_data;
    logic        in_valid, wb_we, ex_read_mem, flush, out_ready;
    logic [4:0]  wb_rd, ex_rd;

    logic        in_ready, out_valid;
    logic [15:0] ctrl_out, stall_cnt;
    logic [31:0] pc_out, rs1_data_out, rs2_data_out, imm_out;
    logic [4:0]  rs1_out, rs2_out, rd_out;
    logic [2:0]  funct3_out;

    logic        nb_in_ready, nb_out_valid;
    logic [15:0] nb_ctrl_out, nb_stall_cnt;
    logic [31:0] nb_pc_out, nb_rs1_data_out, nb_rs2_data_out, nb_imm_out;
    logic [4:0]  nb_rs1_out, nb_rs2_out, nb_rd_out;
    logic [2:0]  nb_funct3_out;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    decode_stage_p #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .instr_in(instr_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_read_mem(ex_read_mem), .ex_rd(ex_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .ctrl_out(ctrl_out),
        .pc_out(pc_out), .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out),
        .imm_out(imm_out), .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out),
        .funct3_out(funct3_out), .stall_cnt(stall_cnt)
    );

    decode_stage_p #(.XLEN(32), .NREGS(32), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .instr_in(instr_in),
        .in_valid(in_valid), .in_ready(nb_in_ready),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_read_mem(ex_read_mem), .ex_rd(ex_rd), .flush(flush),
        .out_valid(nb_out_valid), .out_ready(out_ready), .ctrl_out(nb_ctrl_out),
        .pc_out(nb_pc_out), .rs1_data_out(nb_rs1_data_out), .rs2_data_out(nb_rs2_data_out),
        .imm_out(nb_imm_out), .rs1_out(nb_rs1_out), .rs2_out(nb_rs2_out), .rd_out(nb_rd_out),
        .funct3_out(nb_funct3_out), .stall_cnt(nb_stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [15:0] ctrl,
                                input logic [31:0] imm, input logic [31:0] rs1d,
                                input logic [31:0] rs2d, input logic [31:0] rs2nb,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3);
        exp_t e;
        e = '{pc: pc, ctrl: ctrl, imm: imm, rs1d: rs1d, rs2d: rs2d, rs2nb: rs2nb,
              rd: rd, rs1: rs1, rs2: rs2, f3: f3};
        return e;
    endfunction

    // Call at posedge+#1; returns at posedge+#1 just after the accepting edge.
    task automatic send(input logic [31:0] pc, input logic [31:0] instr, input exp_t e);
        int n;
        pc_in    = pc;
        instr_in = instr;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Call at posedge+#1; write-back is active for exactly one cycle.
    task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
        wb_we   = 1'b1;
        wb_rd   = rd;
        wb_data = data;
        @(posedge clk);
        #1;
        wb_we = 1'b0;
    endtask

    initial begin : monitor
        logic [161:0] snap, prev;
        logic         holding;
        exp_t         e;
        holding = 1'b0;
        prev    = '0;
        forever begin
            @(negedge clk);
            snap = {pc_out, ctrl_out, imm_out, rs1_data_out, rs2_data_out,
                    rd_out, rs1_out, rs2_out, funct3_out};
            if (!rst_n) begin
                holding = 1'b0;
            end else begin
                if (holding && out_valid) begin
                    n_checks++;
                    if (snap !== prev) begin
                        n_fail++;
                        $display("FAIL hold_stable: got %h expected %h", snap, prev);
                    end
                end
                holding = out_valid && !out_ready;
                prev    = snap;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got pc %h expected no output", pc_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pc_out", pc_out, e.pc);
                        chk("ctrl_out", 32'(ctrl_out), 32'(e.ctrl));
                        chk("imm_out", imm_out, e.imm);
                        chk("rs1_data", rs1_data_out, e.rs1d);
                        chk("rs2_data", rs2_data_out, e.rs2d);
                        chk("rd_out", 32'(rd_out), 32'(e.rd));
                        chk("rs1_out", 32'(rs1_out), 32'(e.rs1));
                        chk("rs2_out", 32'(rs2_out), 32'(e.rs2));
                        chk("funct3_out", 32'(funct3_out), 32'(e.f3));
                        chk("nb_valid", 32'(nb_out_valid), 32'd1);
                        chk("nb_rs1_data", nb_rs1_data_out, e.rs1d);
                        chk("nb_rs2_data", nb_rs2_data_out, e.rs2nb);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : stimulus
        rst_n = 1'b0; pc_in = '0; instr_in = '0; in_valid = 1'b0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        ex_read_mem = 1'b0; ex_rd = '0; flush = 1'b0; out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_ctrl", 32'(ctrl_out), 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // addi x1,x0,5 at 0x100: visible two edges after acceptance
        send(32'h100, 32'h00500093, mk(32'h100, 16'h8100, 32'd5, 0, 0, 0, 5'd1, 5'd0, 5'd5, 3'd0));
        @(negedge clk);
        chk("latency_c1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("latency_c2", 32'(out_valid), 32'd1);
        @(posedge clk); #1;

        wb_write(5'd2, 32'h0000_1234);
        wb_write(5'd3, 32'h0000_0055);
        wb_write(5'd0, 32'h0000_FFFF);

        // load-use hazard: add x4,x3,x2 while a load to x3 sits in EX
        ex_read_mem = 1'b1;
        ex_rd       = 5'd3;
        send(32'h104, 32'h00218233,
             mk(32'h104, 16'h8000, 32'd0, 32'h55, 32'h1234, 32'h1234, 5'd4, 5'd3, 5'd2, 3'd0));
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        ex_read_mem = 1'b0;
        @(negedge clk);
        chk("stall_cnt_1", 32'(stall_cnt), 32'd1);
        chk("stall_bubble", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // sub x5,x1,x2 with write-back of x2 in its decode cycle
        send(32'h108, 32'h402082B3,
             mk(32'h108, 16'h8001, 32'd0, 32'd0, 32'hDEAD, 32'h1234, 5'd5, 5'd1, 5'd2, 3'd0));
        wb_write(5'd2, 32'h0000_DEAD);

        // back-to-back stream: sw, blt, lui, jal, unknown opcode
        send(32'h10C, 32'h0020A423,
             mk(32'h10C, 16'h1100, 32'd8, 32'd0, 32'hDEAD, 32'hDEAD, 5'd8, 5'd1, 5'd2, 3'd2));
        send(32'h110, 32'hFE21CCE3,
             mk(32'h110, 16'h0880, 32'hFFFF_FFF8, 32'h55, 32'hDEAD, 32'hDEAD, 5'd25, 5'd3, 5'd2, 3'd4));
        send(32'h114, 32'h12345337,
             mk(32'h114, 16'h8140, 32'h1234_5000, 32'd0, 32'h55, 32'h55, 5'd6, 5'd8, 5'd3, 3'd5));
        send(32'h118, 32'h010000EF,
             mk(32'h118, 16'h8720, 32'd16, 32'd0, 32'd0, 32'd0, 5'd1, 5'd0, 5'd16, 3'd0));
        send(32'h11C, 32'h0000007F,
             mk(32'h11C, 16'h0000, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0));

        // add x9,x0,x0 with a same-cycle write of 0xFFFF to x0
        send(32'h120, 32'h000004B3,
             mk(32'h120, 16'h8000, 32'd0, 32'd0, 32'd0, 32'd0, 5'd9, 5'd0, 5'd0, 3'd0));
        wb_write(5'd0, 32'h0000_FFFF);
        repeat (2) @(posedge clk);
        #1;

        // back-pressure: EX not ready while instructions keep coming
        out_ready = 1'b0;
        send(32'h200, 32'h7FF10513,
             mk(32'h200, 16'h8100, 32'h7FF, 32'hDEAD, 32'd0, 32'd0, 5'd10, 5'd2, 5'd31, 3'd0));
        send(32'h204, 32'h80018593,
             mk(32'h204, 16'h8100, 32'hFFFF_F800, 32'h55, 32'd0, 32'd0, 5'd11, 5'd3, 5'd0, 3'd0));
        @(negedge clk);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_pc", pc_out, 32'h200);
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'h208, 32'h00419613,
             mk(32'h208, 16'h8106, 32'd4, 32'h55, 32'd0, 32'd0, 5'd12, 5'd3, 5'd4, 3'd1));
        repeat (3) @(posedge clk);
        #1;

        // flush with both stages full, a new instruction offered and a write-back
        out_ready = 1'b0;
        send(32'h300, 32'h00500093, mk(32'h300, 16'h8100, 32'd5, 0, 0, 0, 5'd1, 5'd0, 5'd5, 3'd0));
        send(32'h304, 32'h00500093, mk(32'h304, 16'h8100, 32'd5, 0, 0, 0, 5'd1, 5'd0, 5'd5, 3'd0));
        pc_in    = 32'h308;
        instr_in = 32'h00500093;
        in_valid = 1'b1;
        flush    = 1'b1;
        wb_we    = 1'b1;
        wb_rd    = 5'd20;
        wb_data  = 32'h0000_ABCD;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        wb_we    = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_id_empty", 32'(in_ready), 32'd1);
        chk("flush_stall_cnt", 32'(stall_cnt), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("flush_dropped", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        // add x21,x20,x0: the write-back during flush must have landed
        send(32'h30C, 32'h000A0AB3,
             mk(32'h30C, 16'h8000, 32'd0, 32'hABCD, 32'd0, 32'd0, 5'd21, 5'd20, 5'd0, 3'd0));
        repeat (3) @(posedge clk);
        #1;

        // reset in the middle of a hazard stall
        ex_read_mem = 1'b1;
        ex_rd       = 5'd3;
        send(32'h400, 32'h00218233,
             mk(32'h400, 16'h8000, 32'd0, 32'h55, 32'hDEAD, 32'hDEAD, 5'd4, 5'd3, 5'd2, 3'd0));
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("midrst_ctrl", 32'(ctrl_out), 32'd0);
        @(posedge clk); #1;
        ex_read_mem = 1'b0;
        rst_n       = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_no_partial", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        send(32'h404, 32'h000A0AB3,
             mk(32'h404, 16'h8000, 32'd0, 32'd0, 32'd0, 32'd0, 5'd21, 5'd20, 5'd0, 3'd0));

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
